// File: rtl/fifo_wr_ingress.sv
// Write-side ingress: skid-buffered valid/ready stream into the async FIFO write port, with truncation and stats.
// Latency: a word accepted into an empty head is written on the next cycle; one word per cycle sustained.
// Backpressure: head stalls on halffull (packet start) or full; s_ready drops once the skid entry is occupied.
module fifo_wr_ingress #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_PKT    = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   input  logic                  full,
   input  logic                  halffull,
   output logic                  w_en,
   output logic [DATA_WIDTH:0]   wdata,
   input  logic                  err_clr,
   output logic                  pkt_err,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   localparam int CW = $clog2(MAX_PKT + 1);

   typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } word_t;

   word_t          head_word_q, head_word_d, skid_word_q, skid_word_d, s_word;
   logic           head_v_q, head_v_d, skid_v_q, skid_v_d;
   logic           s_ready_q, s_ready_d;
   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           pkt_err_q, pkt_err_d;
   logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d, drop_count_q, drop_count_d;
   logic           push, pop, drop, force_last, err_set;

   assign s_word     = '{last: s_last, data: s_data};
   assign push       = s_valid & s_ready_q;
   assign s_ready    = s_ready_q;
   assign pkt_err    = pkt_err_q;
   assign wr_count   = wr_count_q;
   assign drop_count = drop_count_q;
   assign wdata      = {head_word_q.last | force_last, head_word_q.data};

   // Write strobe and pop decision from registered state and the FIFO flags only.
   always_comb begin
      w_en       = 1'b0;
      force_last = 1'b0;
      drop       = 1'b0;
      case (state_q)
         IDLE: w_en = head_v_q & ~halffull & ~full;
         PKT: begin
            w_en       = head_v_q & ~full;
            // cnt_q words already written, so this is word MAX_PKT when cnt_q hits MAX_PKT-1.
            force_last = w_en & ~head_word_q.last & (cnt_q == CW'(MAX_PKT - 1));
         end
         DROP: drop = head_v_q;
         default: ;
      endcase
      pop = w_en | drop;
   end

   // Two-entry skid buffer: pops refill the head from the skid, pushes land in the first free slot.
   always_comb begin
      head_v_d    = head_v_q;
      head_word_d = head_word_q;
      skid_v_d    = skid_v_q;
      skid_word_d = skid_word_q;
      if (pop) begin
         if (skid_v_q) begin
            head_word_d = skid_word_q;
            skid_v_d    = 1'b0;
         end else begin
            head_v_d = 1'b0;
         end
      end
      // A push only occurs with the skid empty, because s_ready is low whenever it is occupied.
      if (push) begin
         if (!head_v_d) begin
            head_v_d    = 1'b1;
            head_word_d = s_word;
         end else begin
            skid_v_d    = 1'b1;
            skid_word_d = s_word;
         end
      end
      s_ready_d = ~skid_v_d;
   end

   // Packet FSM: gate starts on halffull, count beats, truncate at MAX_PKT and drop the remainder.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_en) begin
               cnt_d = CW'(1);
               if (!head_word_q.last) state_d = PKT;
            end
         end
         PKT: begin
            if (w_en) begin
               cnt_d = cnt_q + CW'(1);
               if (head_word_q.last) begin
                  state_d = IDLE;
               end else if (force_last) begin
                  err_set = 1'b1;
                  state_d = DROP;
               end
            end
         end
         DROP: begin
            if (drop && head_word_q.last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky error and saturating counters; a coincident event overrides the clear.
   always_comb begin
      pkt_err_d    = err_clr ? err_set : (pkt_err_q | err_set);
      wr_count_d   = wr_count_q;
      drop_count_d = drop_count_q;
      if (err_clr) begin
         wr_count_d   = w_en ? CNT_WIDTH'(1) : '0;
         drop_count_d = drop ? CNT_WIDTH'(1) : '0;
      end else begin
         if (w_en && (wr_count_q != {CNT_WIDTH{1'b1}}))
            wr_count_d = wr_count_q + CNT_WIDTH'(1);
         if (drop && (drop_count_q != {CNT_WIDTH{1'b1}}))
            drop_count_d = drop_count_q + CNT_WIDTH'(1);
      end
   end

   // State registers; reset discards buffered words and any partial packet.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         head_v_q     <= 1'b0;
         head_word_q  <= '0;
         skid_v_q     <= 1'b0;
         skid_word_q  <= '0;
         s_ready_q    <= 1'b1;
         state_q      <= IDLE;
         cnt_q        <= '0;
         pkt_err_q    <= 1'b0;
         wr_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         head_v_q     <= head_v_d;
         head_word_q  <= head_word_d;
         skid_v_q     <= skid_v_d;
         skid_word_q  <= skid_word_d;
         s_ready_q    <= s_ready_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pkt_err_q    <= pkt_err_d;
         wr_count_q   <= wr_count_d;
         drop_count_q <= drop_count_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Bench for fifo_wr_ingress: directed packets with a packet-level reference model and per-cycle write checks.
// Latency: n/a (testbench).
// Backpressure: drives full/halffull directly; the driver holds words until s_ready accepts them.
module tb_fifo_wr_ingress;

   localparam int DW = 8;
   localparam int MP = 64;
   localparam int CW = 16;

   logic          wclk = 1'b0;
   logic          wrst_n, s_valid, s_ready, s_last, full, halffull, w_en, err_clr, pkt_err;
   logic [DW-1:0] s_data;
   logic [DW:0]   wdata;
   logic [CW-1:0] wr_count, drop_count;

   fifo_wr_ingress #(.DATA_WIDTH(DW), .MAX_PKT(MP), .CNT_WIDTH(CW)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .full(full), .halffull(halffull), .w_en(w_en), .wdata(wdata),
      .err_clr(err_clr), .pkt_err(pkt_err), .wr_count(wr_count), .drop_count(drop_count)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   int          checks = 0;
   int          errors = 0;
   beat_t       drv_q[$];
   logic [DW:0] exp_q[$];
   int          pkt_idx = 0, exp_wr = 0, exp_drop = 0;
   logic        exp_err = 1'b0;
   int          cyc = 0, wen_total = 0, acc_total = 0;
   int          wen_cyc[$], acc_cyc[$];
   logic        wen_last[$];
   logic        drv_acc;
   int          w0, a0, f0;

   always @(posedge wclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference model: packet word index decides write (with forced last) or drop.
   task automatic model_accept(input logic [DW-1:0] d, input logic l);
      pkt_idx++;
      if (pkt_idx <= MP) begin
         exp_q.push_back({l | (pkt_idx == MP), d});
         exp_wr++;
         if (pkt_idx == MP && !l) exp_err = 1'b1;
      end else begin
         exp_drop++;
      end
      if (l) pkt_idx = 0;
   endtask

   // Monitor: checks every write against the model and feeds accepted words into it.
   initial begin
      forever begin
         @(negedge wclk);
         if (wrst_n) begin
            checks++;
            if (full && w_en) begin
               errors++;
               $display("FAIL w_en_while_full: w_en=1 expected 0 at cycle %0d", cyc);
            end
            if (w_en) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: wdata=0x%0h with no expected word pending", wdata);
               end else begin
                  chk("wdata", 32'(wdata), 32'(exp_q.pop_front()));
               end
               wen_total++;
               wen_cyc.push_back(cyc);
               wen_last.push_back(wdata[DW]);
            end
            if (s_valid && s_ready) begin
               acc_total++;
               acc_cyc.push_back(cyc);
               model_accept(s_data, s_last);
            end
         end
      end
   end

   // Stream driver: presents queued words and advances after each accepted transfer.
   initial begin
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      forever begin
         @(negedge wclk);
         drv_acc = s_valid && s_ready && wrst_n;
         @(posedge wclk);
         #1;
         if (drv_acc && drv_q.size() > 0) void'(drv_q.pop_front());
         if (drv_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = drv_q[0].d;
            s_last  = drv_q[0].l;
         end else begin
            s_valid = 1'b0;
         end
      end
   end

   task automatic push_pkt(input int n, input int seed);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d = DW'(seed + i);
         b.l = (i == n - 1);
         drv_q.push_back(b);
      end
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge wclk);
         #1;
         if (drv_q.size() == 0 && !s_valid && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, 32'(done), 32'd1);
      repeat (6) @(posedge wclk);
   endtask

   task automatic wait_wen(input string name, input int target);
      logic done;
      done = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge wclk);
         #1;
         if (wen_total >= target) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, 32'(done), 32'd1);
   endtask

   task automatic check_stats(input string name);
      chk({name, "_model_wr"}, 32'(wr_count), 32'(exp_wr));
      chk({name, "_model_drop"}, 32'(drop_count), 32'(exp_drop));
      chk({name, "_model_err"}, 32'(pkt_err), 32'(exp_err));
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, "_s_ready"}, 32'(s_ready), 32'd1);
      chk({name, "_w_en"}, 32'(w_en), 32'd0);
      chk({name, "_wdata"}, 32'(wdata), 32'd0);
      chk({name, "_pkt_err"}, 32'(pkt_err), 32'd0);
      chk({name, "_wr_count"}, 32'(wr_count), 32'd0);
      chk({name, "_drop_count"}, 32'(drop_count), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      wrst_n   = 1'b0;
      full     = 1'b0;
      halffull = 1'b0;
      err_clr  = 1'b0;
      repeat (3) @(posedge wclk);
      #1;
      check_reset_vals("reset");
      @(posedge wclk);
      #3 wrst_n = 1'b1;

      // Back-to-back 4-word packets.
      w0 = wen_total; a0 = acc_total;
      push_pkt(4, 'h10);
      push_pkt(4, 'h20);
      wait_idle("t1_idle");
      chk("t1_first_latency", 32'(wen_cyc[w0] - acc_cyc[a0]), 32'd1);
      chk("t1_run_length", 32'(wen_cyc[w0+7] - wen_cyc[w0]), 32'd7);
      chk("t1_last_w4", 32'(wen_last[w0+3]), 32'd1);
      chk("t1_last_w8", 32'(wen_last[w0+7]), 32'd1);
      chk("t1_last_w3", 32'(wen_last[w0+2]), 32'd0);
      chk("t1_writes", 32'(wen_total - w0), 32'd8);
      chk("t1_wr_count", 32'(wr_count), 32'd8);
      check_stats("t1");

      // halffull gates the packet start only.
      @(posedge wclk);
      #3 halffull = 1'b1;
      w0 = wen_total; a0 = acc_total;
      push_pkt(3, 'h40);
      repeat (6) @(posedge wclk);
      #3;
      chk("t2_accepted", 32'(acc_total - a0), 32'd2);
      chk("t2_s_ready_low", 32'(s_ready), 32'd0);
      chk("t2_no_write", 32'(wen_total - w0), 32'd0);
      halffull = 1'b0;
      #1;
      chk("t2_wen_on_fall", 32'(w_en), 32'd1);
      @(posedge wclk);
      #3 halffull = 1'b1;
      wait_idle("t2_idle");
      halffull = 1'b0;
      chk("t2_writes", 32'(wen_total - w0), 32'd3);
      chk("t2_wr_count", 32'(wr_count), 32'd11);
      check_stats("t2");

      // full for 5 cycles mid-packet.
      w0 = wen_total;
      push_pkt(10, 'h60);
      wait_wen("t3_reach3", w0 + 3);
      @(posedge wclk);
      #3 full = 1'b1;
      f0 = wen_total;
      repeat (5) @(posedge wclk);
      #3;
      chk("t3_none_while_full", 32'(wen_total - f0), 32'd0);
      full = 1'b0;
      #1;
      chk("t3_resume_same_cycle", 32'(w_en), 32'd1);
      wait_idle("t3_idle");
      chk("t3_writes", 32'(wen_total - w0), 32'd10);
      chk("t3_wr_count", 32'(wr_count), 32'd21);
      check_stats("t3");

      // Over-length packet truncated, then a normal packet.
      w0 = wen_total;
      push_pkt(MP + 3, 'h80);
      push_pkt(2, 'h05);
      wait_idle("t4_idle");
      chk("t4_writes", 32'(wen_total - w0), 32'd66);
      chk("t4_last_w64", 32'(wen_last[w0+63]), 32'd1);
      chk("t4_last_w63", 32'(wen_last[w0+62]), 32'd0);
      chk("t4_pkt_err", 32'(pkt_err), 32'd1);
      chk("t4_drop_count", 32'(drop_count), 32'd3);
      chk("t4_wr_count", 32'(wr_count), 32'd87);
      check_stats("t4");

      // Clear, exact-length packet, then clear coinciding with a drop.
      @(posedge wclk);
      #3 err_clr = 1'b1;
      @(posedge wclk);
      #3 err_clr = 1'b0;
      exp_wr = 0; exp_drop = 0; exp_err = 1'b0;
      chk("t5_clr_err", 32'(pkt_err), 32'd0);
      chk("t5_clr_wr", 32'(wr_count), 32'd0);
      chk("t5_clr_drop", 32'(drop_count), 32'd0);
      w0 = wen_total;
      push_pkt(MP, 'h00);
      wait_idle("t5_exact_idle");
      chk("t5_exact_err", 32'(pkt_err), 32'd0);
      chk("t5_exact_wr", 32'(wr_count), 32'd64);
      chk("t5_exact_last", 32'(wen_last[w0+63]), 32'd1);
      check_stats("t5_exact");
      w0 = wen_total;
      push_pkt(MP + 1, 'h30);
      wait_wen("t5_reach64", w0 + 64);
      @(posedge wclk);
      #3 err_clr = 1'b1;
      #1;
      chk("t5_err_before_clr", 32'(pkt_err), 32'd1);
      @(posedge wclk);
      #3 err_clr = 1'b0;
      exp_wr = 0; exp_drop = 1; exp_err = 1'b0;
      chk("t5_set_wins_drop", 32'(drop_count), 32'd1);
      chk("t5_clr_err2", 32'(pkt_err), 32'd0);
      chk("t5_clr_wr2", 32'(wr_count), 32'd0);
      wait_idle("t5_idle");
      check_stats("t5");

      // Reset with both buffer entries occupied.
      @(posedge wclk);
      #3 halffull = 1'b1;
      a0 = acc_total;
      push_pkt(3, 'hA0);
      repeat (6) @(posedge wclk);
      #3;
      chk("t6_both_full", 32'(acc_total - a0), 32'd2);
      chk("t6_s_ready_low", 32'(s_ready), 32'd0);
      wrst_n = 1'b0;
      drv_q.delete();
      exp_q.delete();
      pkt_idx = 0; exp_wr = 0; exp_drop = 0; exp_err = 1'b0;
      #1;
      check_reset_vals("t6_reset");
      @(posedge wclk);
      @(posedge wclk);
      #3 wrst_n = 1'b1;
      halffull = 1'b0;
      w0 = wen_total; a0 = acc_total;
      push_pkt(2, 'h50);
      wait_idle("t6_idle");
      chk("t6_writes", 32'(wen_total - w0), 32'd2);
      chk("t6_first_latency", 32'(wen_cyc[w0] - acc_cyc[a0]), 32'd1);
      chk("t6_wr_count", 32'(wr_count), 32'd2);
      check_stats("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
